// File: rtl/mdio_phy_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdio_phy_responder                                           |
// | Description : MDIO (clause 22) PHY-side management responder. Samples the  |
// |               MDC/MDIO lines in the clk_clk domain, decodes read and write |
// |               frames, and serves a small register map: ctrl (0),          |
// |               status (1), PHY ID (2,3), scratch (4-7).                     |
// | Option      : MDIO_PREAMBLE_SUPPRESS_EN - accept a frame after a preamble  |
// |               of one or more 1s and report bit 6 of register 1 as 1.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic [15:0] status_in,
  output logic [15:0] ctrl_out,
  output logic        frame_err
);

  // Preamble length that arms start-of-frame detection.
  localparam logic [5:0]  c_pre_full = 6'd32;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0]  c_pre_min      = 6'd1;
  localparam logic [15:0] c_status_force = 16'h0040;
`else
  localparam logic [5:0]  c_pre_min      = 6'd32;
  localparam logic [15:0] c_status_force = 16'h0000;
`endif
  // Idle clk count (minus one) after which a stalled frame is abandoned.
  localparam logic [7:0]  c_idle_max = 8'd255;

  typedef enum logic [2:0] {
    S_PRE   = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6
  } state_t;

  logic [1:0]  r_mdc_sync;
  logic [1:0]  r_mdio_sync;
  logic        r_mdc_prev;

  state_t      r_state;
  logic [5:0]  r_pre_cnt;
  logic [4:0]  r_bit_cnt;
  logic        r_op_hi;
  logic [4:0]  r_phyad;
  logic [4:0]  r_regad;
  logic        r_is_read;
  logic        r_addressed;
  logic [15:0] r_shift;
  logic [7:0]  r_idle_cnt;
  logic        r_mdio_out;
  logic        r_mdio_oen;
  logic        r_frame_err;

  logic [15:0] r_ctrl;
  logic [15:0] r_scratch [0:3];

  logic        w_mdc_rise;
  logic        w_bit;
  logic [4:0]  w_regad_full;
  logic [15:0] w_rd_data;
  logic [15:0] w_wr_data;
  logic        w_wr_en;
  logic        w_timeout;

  assign w_mdc_rise   = r_mdc_sync[1] & ~r_mdc_prev;
  assign w_bit        = r_mdio_sync[1];
  assign w_regad_full = {r_regad[3:0], w_bit};
  assign w_wr_data    = {r_shift[14:0], w_bit};

  // A write commits on the 16th data edge, only for a frame aimed at us.
  assign w_wr_en = w_mdc_rise && (r_state == S_DATA) && (r_bit_cnt == 5'd15) &&
                   !r_is_read && r_addressed;

  // A frame in flight that has seen no MDC edge for 256 clk is abandoned.
  assign w_timeout = (r_state != S_PRE) && !w_mdc_rise && (r_idle_cnt == c_idle_max);

  assign mdio_out  = r_mdio_out;
  assign mdio_oen  = r_mdio_oen;
  assign frame_err = r_frame_err;
  assign ctrl_out  = r_ctrl;

  // Two-stage synchronizers for MDC and MDIO plus the MDC edge history bit.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_mdc_sync  <= 2'b00;
      r_mdio_sync <= 2'b00;
      r_mdc_prev  <= 1'b0;
    end else begin
      r_mdc_sync  <= {r_mdc_sync[0], mdc};
      r_mdio_sync <= {r_mdio_sync[0], mdio_in};
      r_mdc_prev  <= r_mdc_sync[1];
    end
  end

  // Read mux, evaluated with the final REGAD bit so data is ready at TA entry.
  always_comb begin
    w_rd_data = 16'h0000;
    case (w_regad_full)
      5'd0:                w_rd_data = r_ctrl;
      5'd1:                w_rd_data = status_in | c_status_force;
      5'd2:                w_rd_data = PHY_ID1;
      5'd3:                w_rd_data = PHY_ID2;
      5'd4, 5'd5, 5'd6, 5'd7:
                           w_rd_data = r_scratch[w_regad_full[1:0]];
      default:             w_rd_data = 16'h0000;
    endcase
  end

  // Frame decoder: one step per MDC rising edge, outputs registered.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state     <= S_PRE;
      r_pre_cnt   <= 6'd0;
      r_bit_cnt   <= 5'd0;
      r_op_hi     <= 1'b0;
      r_phyad     <= 5'd0;
      r_regad     <= 5'd0;
      r_is_read   <= 1'b0;
      r_addressed <= 1'b0;
      r_shift     <= 16'h0000;
      r_idle_cnt  <= 8'd0;
      r_mdio_out  <= 1'b0;
      r_mdio_oen  <= 1'b1;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_timeout) begin
        r_state     <= S_PRE;
        r_pre_cnt   <= 6'd0;
        r_bit_cnt   <= 5'd0;
        r_idle_cnt  <= 8'd0;
        r_mdio_oen  <= 1'b1;
        r_mdio_out  <= 1'b0;
        r_frame_err <= 1'b1;
      end else if (w_mdc_rise) begin
        r_idle_cnt <= 8'd0;
        case (r_state)
          S_PRE: begin
            if (w_bit) begin
              if (r_pre_cnt != c_pre_full) begin
                r_pre_cnt <= r_pre_cnt + 6'd1;
              end
            end else if (r_pre_cnt >= c_pre_min) begin
              // This 0 is the first start bit.
              r_state   <= S_ST;
              r_pre_cnt <= 6'd0;
            end else begin
              r_pre_cnt <= 6'd0;
            end
          end

          S_ST: begin
            if (w_bit) begin
              r_state   <= S_OP;
              r_bit_cnt <= 5'd0;
            end else begin
              r_state     <= S_PRE;
              r_frame_err <= 1'b1;
            end
          end

          S_OP: begin
            if (r_bit_cnt == 5'd0) begin
              r_op_hi   <= w_bit;
              r_bit_cnt <= 5'd1;
            end else begin
              r_bit_cnt <= 5'd0;
              if ({r_op_hi, w_bit} == 2'b10) begin
                r_is_read <= 1'b1;
                r_state   <= S_PHYAD;
              end else if ({r_op_hi, w_bit} == 2'b01) begin
                r_is_read <= 1'b0;
                r_state   <= S_PHYAD;
              end else begin
                r_state     <= S_PRE;
                r_frame_err <= 1'b1;
              end
            end
          end

          S_PHYAD: begin
            r_phyad <= {r_phyad[3:0], w_bit};
            if (r_bit_cnt == 5'd4) begin
              r_bit_cnt <= 5'd0;
              r_state   <= S_REGAD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          S_REGAD: begin
            r_regad <= w_regad_full;
            if (r_bit_cnt == 5'd4) begin
              // Snapshot read data now so later status_in changes cannot leak in.
              r_bit_cnt   <= 5'd0;
              r_state     <= S_TA;
              r_addressed <= (r_phyad == PHY_ADDR);
              r_shift     <= w_rd_data;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          S_TA: begin
            if (r_bit_cnt == 5'd0) begin
              r_bit_cnt <= 5'd1;
              if (r_is_read && r_addressed) begin
                r_mdio_oen <= 1'b0;
                r_mdio_out <= 1'b0;
              end
            end else begin
              r_bit_cnt <= 5'd0;
              r_state   <= S_DATA;
              if (r_is_read && r_addressed) begin
                r_mdio_out <= r_shift[15];
                r_shift    <= {r_shift[14:0], 1'b0};
              end
            end
          end

          S_DATA: begin
            if (r_is_read) begin
              if (r_addressed && (r_bit_cnt != 5'd15)) begin
                r_mdio_out <= r_shift[15];
                r_shift    <= {r_shift[14:0], 1'b0};
              end
            end else begin
              r_shift <= w_wr_data;
            end
            if (r_bit_cnt == 5'd15) begin
              // Last data edge: release the line and rearm preamble detection.
              r_state    <= S_PRE;
              r_bit_cnt  <= 5'd0;
              r_pre_cnt  <= 6'd0;
              r_mdio_oen <= 1'b1;
              r_mdio_out <= 1'b0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end

          default: begin
            r_state   <= S_PRE;
            r_pre_cnt <= 6'd0;
            r_bit_cnt <= 5'd0;
          end
        endcase
      end else if (r_state != S_PRE) begin
        r_idle_cnt <= r_idle_cnt + 8'd1;
      end else begin
        r_idle_cnt <= 8'd0;
      end
    end
  end

  // Writable registers; ctrl bit 15 is a one-clk self-clearing command bit.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_ctrl <= 16'h0000;
      for (int i = 0; i < 4; i++) begin
        r_scratch[i] <= 16'h0000;
      end
    end else begin
      if (w_wr_en && (r_regad == 5'd0)) begin
        r_ctrl <= w_wr_data;
      end else if (r_ctrl[15]) begin
        r_ctrl[15] <= 1'b0;
      end
      if (w_wr_en && (r_regad[4:2] == 3'b001)) begin
        r_scratch[r_regad[1:0]] <= w_wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdio_phy_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mdio_phy_responder                                        |
// | Description : Directed bench for mdio_phy_responder with a frame-level     |
// |               reference model and a per-bit compare process.              |
// | Option      : MDIO_PREAMBLE_SUPPRESS_EN changes expected preamble handling.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mdio_phy_responder;

  localparam int H = 6;   // clk cycles per MDC phase
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam bit SUP = 1'b1;
`else
  localparam bit SUP = 1'b0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        mdc = 1'b0;
  logic        mdio_in = 1'b1;
  logic [15:0] status_in = 16'h0000;
  logic        mdio_out;
  logic        mdio_oen;
  logic [15:0] ctrl_out;
  logic        frame_err;

  always #5 clk_clk = ~clk_clk;

  mdio_phy_responder #(
    .PHY_ADDR (5'd1),
    .PHY_ID1  (16'h0141),
    .PHY_ID2  (16'h0CC2)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .mdc         (mdc),
    .mdio_in     (mdio_in),
    .mdio_out    (mdio_out),
    .mdio_oen    (mdio_oen),
    .status_in   (status_in),
    .ctrl_out    (ctrl_out),
    .frame_err   (frame_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_ctrl = 16'h0000;
  logic [15:0] m_scr [4];

  function automatic logic [15:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return m_ctrl;
    if (a == 5'd1) return status_in | (SUP ? 16'h0040 : 16'h0000);
    if (a == 5'd2) return 16'h0141;
    if (a == 5'd3) return 16'h0CC2;
    if (a >= 5'd4 && a <= 5'd7) return m_scr[a[1:0]];
    return 16'h0000;
  endfunction

  task automatic m_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd0) m_ctrl = d & 16'h7FFF;
    else if (a >= 5'd4 && a <= 5'd7) m_scr[a[1:0]] = d;
  endtask

  task automatic m_reset();
    m_ctrl = 16'h0000;
    for (int i = 0; i < 4; i++) m_scr[i] = 16'h0000;
  endtask

  // ---------------- monitors ----------------
  int          err_cnt = 0;
  int          pulse_cnt = 0;
  logic [15:0] pulse_val = 16'h0000;

  always @(posedge clk_clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (ctrl_out[15] === 1'b1) begin
      pulse_cnt++;
      pulse_val = ctrl_out;
    end
  end

  // ---------------- compare process ----------------
  event  sample_ev;
  logic  exp_oen = 1'b1;
  logic  exp_out = 1'b0;
  string exp_tag = "";

  initial forever begin
    @(sample_ev);
    chk({exp_tag, " oen"}, {15'd0, mdio_oen}, {15'd0, exp_oen});
    if (!exp_oen) chk({exp_tag, " out"}, {15'd0, mdio_out}, {15'd0, exp_out});
    chk({exp_tag, " ctrl_out"}, ctrl_out, m_ctrl);
  end

  // ---------------- stimulus helpers ----------------
  int          chg_at = -1;
  logic [15:0] chg_val = 16'h0000;
  int          frame_no = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    mdc = 1'b0;
    mdio_in = b;
    tick(H);
    mdc = 1'b1;
    tick(H);
  endtask

  // abort_kind: 1 = stop MDC for 300 clk, 2 = pulse reset, 3 = just stop sending
  task automatic frame(input int npre, input logic [1:0] st, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] wd,
                       input int abort_at, input int abort_kind,
                       output logic [15:0] rd, output logic drove);
    logic [31:0] fb;
    logic        acc, ok, answer, do_write;
    logic [15:0] rv;
    acc      = (npre >= 32) || (SUP && npre >= 1);
    ok       = acc && (st == 2'b01) && (phy == 5'd1);
    answer   = ok && (op == 2'b10);
    do_write = ok && (op == 2'b01) && (abort_at < 0);
    rv       = m_read(ra);
    fb       = {st, op, phy, ra, (op == 2'b01) ? 2'b10 : 2'b11, (op == 2'b01) ? wd : 16'hFFFF};
    rd       = 16'h0000;
    drove    = 1'b0;
    frame_no++;
    for (int i = 0; i < npre; i++) begin
      send_bit(1'b1);
      exp_tag = $sformatf("f%0d pre%0d", frame_no, i);
      exp_oen = 1'b1;
      drove   = drove | ~mdio_oen;
      -> sample_ev;
    end
    for (int k = 0; k < 32; k++) begin
      if (k == chg_at) status_in = chg_val;
      send_bit(fb[31-k]);
      if (k == 31 && do_write) m_write(ra, wd);
      exp_tag = $sformatf("f%0d bit%0d", frame_no, k);
      exp_oen = !(answer && k >= 14 && k <= 30);
      exp_out = (k >= 15 && k <= 30) ? rv[30-k] : 1'b0;
      if (k >= 15 && k <= 30) rd[30-k] = mdio_out;
      drove = drove | ~mdio_oen;
      -> sample_ev;
      if (k == abort_at) begin
        if (abort_kind == 1) begin
          mdc = 1'b0;
          tick(300);
        end else if (abort_kind == 2) begin
          tick(2);
          reset_reset = 1'b1;
          tick(3);
          reset_reset = 1'b0;
          m_reset();
          tick(2);
        end
        return;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] rd;
    logic        dr;
    int          e0, p0;
    m_reset();

    tick(4);
    chk("reset oen", {15'd0, mdio_oen}, 16'd1);
    chk("reset out", {15'd0, mdio_out}, 16'd0);
    chk("reset ctrl_out", ctrl_out, 16'h0000);
    chk("reset frame_err", {15'd0, frame_err}, 16'd0);
    reset_reset = 1'b0;
    tick(4);

    // Read PHY ID1
    frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, -1, 0, rd, dr);
    chk("id1 read data", rd, 16'h0141);
    chk("id1 oen after", {15'd0, mdio_oen}, 16'd1);

    // Scratch write/read, unmapped read
    frame(32, 2'b01, 2'b01, 5'd1, 5'd5, 16'hA5A5, -1, 0, rd, dr);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd5, 16'h0, -1, 0, rd, dr);
    chk("reg5 readback", rd, 16'hA5A5);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd9, 16'h0, -1, 0, rd, dr);
    chk("reg9 read", rd, 16'h0000);
    chk("reg9 drove", {15'd0, dr}, 16'd1);

    // Self-clearing ctrl bit 15
    p0 = pulse_cnt;
    frame(32, 2'b01, 2'b01, 5'd1, 5'd0, 16'h8040, -1, 0, rd, dr);
    tick(2);
    chk("ctrl pulse clocks", 16'(pulse_cnt - p0), 16'd1);
    chk("ctrl pulse value", pulse_val, 16'h8040);
    chk("ctrl after pulse", ctrl_out, 16'h0040);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd0, 16'h0, -1, 0, rd, dr);
    chk("reg0 readback", rd, 16'h0040);

    // Write to read-only register is ignored
    frame(32, 2'b01, 2'b01, 5'd1, 5'd2, 16'hFFFF, -1, 0, rd, dr);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, -1, 0, rd, dr);
    chk("reg2 after ro write", rd, 16'h0141);

    // Other PHY address, then ours
    frame(32, 2'b01, 2'b10, 5'd2, 5'd3, 16'h0, -1, 0, rd, dr);
    chk("phyad2 drove", {15'd0, dr}, 16'd0);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd3, 16'h0, -1, 0, rd, dr);
    chk("id2 read data", rd, 16'h0CC2);

    // Status captured at TA entry, later change ignored
    status_in = 16'h1234;
    chg_at = 20;
    chg_val = 16'hFFFF;
    frame(32, 2'b01, 2'b10, 5'd1, 5'd1, 16'h0, -1, 0, rd, dr);
    chg_at = -1;
    chk("status snapshot", rd, SUP ? 16'h1274 : 16'h1234);

    // Short preamble
    frame(20, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, -1, 0, rd, dr);
    chk("short preamble drove", {15'd0, dr}, {15'd0, SUP});

    // MDC stall mid-write
    frame(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'h5A5A, -1, 0, rd, dr);
    e0 = err_cnt;
    frame(32, 2'b01, 2'b01, 5'd1, 5'd4, 16'h1234, 23, 1, rd, dr);
    chk("stall frame_err", 16'(err_cnt - e0), 16'd1);
    chk("stall oen", {15'd0, mdio_oen}, 16'd1);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd4, 16'h0, -1, 0, rd, dr);
    chk("reg4 after stall", rd, 16'h5A5A);

    // Reset mid-read
    e0 = err_cnt;
    frame(32, 2'b01, 2'b10, 5'd1, 5'd5, 16'h0, 22, 2, rd, dr);
    chk("reset abort frame_err", 16'(err_cnt - e0), 16'd0);
    chk("reset abort oen", {15'd0, mdio_oen}, 16'd1);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd2, 16'h0, -1, 0, rd, dr);
    chk("id1 after reset", rd, 16'h0141);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd5, 16'h0, -1, 0, rd, dr);
    chk("reg5 after reset", rd, 16'h0000);

    // Bad start bits
    e0 = err_cnt;
    frame(32, 2'b00, 2'b10, 5'd1, 5'd2, 16'h0, 1, 3, rd, dr);
    tick(4);
    chk("bad st frame_err", 16'(err_cnt - e0), 16'd1);
    frame(32, 2'b01, 2'b10, 5'd1, 5'd3, 16'h0, -1, 0, rd, dr);
    chk("id2 after bad st", rd, 16'h0CC2);

    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
